// File: rtl/ldst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldst_pkg
// Purpose  : Shared definitions for the load/store path. Holds the access-size
//            encodings, the EXU request/response and data-bus packet types,
//            and the LSU state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package ldst_pkg;

    localparam int LDST_XLEN = 32;

    localparam logic [1:0] LDST_SIZE_B = 2'd0;
    localparam logic [1:0] LDST_SIZE_H = 2'd1;
    localparam logic [1:0] LDST_SIZE_W = 2'd2;

    typedef struct packed {
        logic [LDST_XLEN-1:0] addr;
        logic [LDST_XLEN-1:0] wdata;
        logic                 is_store;
        logic [1:0]           size;
        logic                 is_unsigned;
    } ldst_req_pkt_t;

    typedef struct packed {
        logic [LDST_XLEN-1:0] rdata;
        logic                 err;
    } ldst_rsp_pkt_t;

    typedef struct packed {
        logic [LDST_XLEN-1:0] addr;
        logic                 we;
        logic [LDST_XLEN-1:0] wdata;
        logic [3:0]           wstrb;
    } dbus_req_pkt_t;

    typedef struct packed {
        logic [LDST_XLEN-1:0] rdata;
        logic                 err;
    } dbus_rsp_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Purpose  : Combinational byte-lane logic for the LSU: store-data
//            replication, write-strobe generation, load-data extraction with
//            sign/zero extension, and misalignment detection.
// Ports    : addr_lo     - low two address bits of the access
//            size        - access size (byte/half/word)
//            is_unsigned - zero-extend load data when set
//            wdata       - raw store data from the EXU
//            bus_rdata   - raw word returned by the data bus
//            wdata_rep   - store data replicated across all lanes
//            wstrb       - byte strobes of the access (before load gating)
//            load_data   - aligned and extended load result
//            misalign    - access is not naturally aligned
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
    import ldst_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  off;      // effective byte offset after forced alignment
    logic [31:0] shifted;

    always_comb begin
        off       = 2'b00;
        wdata_rep = wdata;
        wstrb     = 4'b1111;
        misalign  = 1'b0;
        case (size)
            LDST_SIZE_B: begin
                off       = addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
            end
            LDST_SIZE_H: begin
                // addr[0] is ignored; the half always lands on an even lane
                off       = {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                misalign  = addr_lo[0];
            end
            default: begin
                // word (size 3 never reaches the bus, so its lanes are moot)
                misalign = |addr_lo;
            end
        endcase

        shifted = bus_rdata >> {off, 3'b000};

        case (size)
            LDST_SIZE_B: load_data = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            LDST_SIZE_H: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:     load_data = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit. Accepts one EXU load/store at a time, issues a
//            single outstanding data-bus transaction, and returns exactly one
//            aligned/extended response per request.
// Params   : XLEN        - data/address width (must equal LDST_XLEN)
//            TIMEOUT_CYC - cycles waited for a bus response, 0 = wait forever
// Macro    : LSU_MISALIGN_TRAP_EN - misaligned half/word accesses respond
//            with err=1 and issue no bus request; otherwise they are forced
//            aligned and proceed.
// Ports    : clk, rst (async, active-high)
//            ldst_req_*  - EXU request channel (vld/rdy/pkt), LSU is responder
//            ldst_rsp_*  - EXU response channel, LSU is master
//            dbus_req_*  - data-bus request channel, LSU is master
//            dbus_rsp_*  - data-bus response channel, LSU is responder
// Revision : 1.0 - initial release
// ============================================================================
module lsu
    import ldst_pkg::*;
#(
    parameter int XLEN        = LDST_XLEN,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ldst_req_vld,
    output logic          ldst_req_rdy,
    input  ldst_req_pkt_t ldst_req_pkt,
    output logic          ldst_rsp_vld,
    input  logic          ldst_rsp_rdy,
    output ldst_rsp_pkt_t ldst_rsp_pkt,
    output logic          dbus_req_vld,
    input  logic          dbus_req_rdy,
    output dbus_req_pkt_t dbus_req_pkt,
    input  logic          dbus_rsp_vld,
    output logic          dbus_rsp_rdy,
    input  dbus_rsp_pkt_t dbus_rsp_pkt
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    lsu_state_e    state, state_nxt;
    ldst_req_pkt_t req_q;
    ldst_req_pkt_t lane_req;
    logic [XLEN-1:0] rsp_rdata_q;
    logic          rsp_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic          timeout;
    logic          trap;
    logic [31:0]   wdata_rep;
    logic [3:0]    wstrb;
    logic [31:0]   load_data;
    logic          misalign;

    // In IDLE the lane looks at the incoming packet so the trap decision is
    // made at accept time; afterwards it works on the latched packet.
    assign lane_req = (state == ST_IDLE) ? ldst_req_pkt : req_q;

    lsu_lane u_lane (
        .addr_lo     (lane_req.addr[1:0]),
        .size        (lane_req.size),
        .is_unsigned (lane_req.is_unsigned),
        .wdata       (lane_req.wdata),
        .bus_rdata   (dbus_rsp_pkt.rdata),
        .wdata_rep   (wdata_rep),
        .wstrb       (wstrb),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    // Requests answered locally without touching the bus
    assign trap = (lane_req.size == 2'd3) | (MISALIGN_TRAP & misalign);

    generate
        if (TIMEOUT_CYC != 0) begin : g_timeout
            assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready signals are masked by rst so nothing transfers while in reset.
    always_comb begin
        state_nxt    = state;
        ldst_req_rdy = 1'b0;
        ldst_rsp_vld = 1'b0;
        dbus_req_vld = 1'b0;
        dbus_rsp_rdy = 1'b0;
        case (state)
            ST_IDLE: begin
                ldst_req_rdy = ~rst;
                dbus_rsp_rdy = ~rst;   // stray responses are swallowed
                if (ldst_req_vld) state_nxt = trap ? ST_RSP : ST_REQ;
            end
            ST_REQ: begin
                dbus_req_vld = 1'b1;
                dbus_rsp_rdy = ~rst;
                if (dbus_req_rdy) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                dbus_rsp_rdy = ~rst;
                if (dbus_rsp_vld || timeout) state_nxt = ST_RSP;
            end
            ST_RSP: begin
                ldst_rsp_vld = 1'b1;
                if (ldst_rsp_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ldst_req_vld) begin
                        req_q       <= ldst_req_pkt;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= trap;
                    end
                end
                ST_REQ: begin
                    if (dbus_req_rdy) cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (dbus_rsp_vld) begin
                        // Stores and bus errors return zero data
                        rsp_err_q   <= dbus_rsp_pkt.err;
                        rsp_rdata_q <= (dbus_rsp_pkt.err || req_q.is_store) ? '0 : load_data;
                    end else if (timeout) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ldst_rsp_pkt.rdata  = rsp_rdata_q;
    assign ldst_rsp_pkt.err    = rsp_err_q;

    assign dbus_req_pkt.addr   = {req_q.addr[XLEN-1:2], 2'b00};
    assign dbus_req_pkt.we     = req_q.is_store;
    assign dbus_req_pkt.wdata  = req_q.is_store ? wdata_rep : '0;
    assign dbus_req_pkt.wstrb  = req_q.is_store ? wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Directed cases followed by random
//            transactions, each compared against a behavioural model of the
//            load/store rules (lane offsets, strobes, extension, timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
    import ldst_pkg::*;

    localparam int TO  = 4;
    localparam int LIM = 50;

    logic          clk;
    logic          rst;
    logic          ldst_req_vld;
    logic          ldst_req_rdy;
    ldst_req_pkt_t ldst_req_pkt;
    logic          ldst_rsp_vld;
    logic          ldst_rsp_rdy;
    ldst_rsp_pkt_t ldst_rsp_pkt;
    logic          dbus_req_vld;
    logic          dbus_req_rdy;
    dbus_req_pkt_t dbus_req_pkt;
    logic          dbus_rsp_vld;
    logic          dbus_rsp_rdy;
    dbus_rsp_pkt_t dbus_rsp_pkt;

    int n_cmp = 0;
    int n_mis = 0;
    int bus_xfers = 0;
    int rsp_xfers = 0;

    logic [31:0] last_rd, last_daddr, last_dwdata;
    logic        last_er, last_dwe;
    logic [3:0]  last_dwstrb;

    lsu #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ldst_req_vld (ldst_req_vld),
        .ldst_req_rdy (ldst_req_rdy),
        .ldst_req_pkt (ldst_req_pkt),
        .ldst_rsp_vld (ldst_rsp_vld),
        .ldst_rsp_rdy (ldst_rsp_rdy),
        .ldst_rsp_pkt (ldst_rsp_pkt),
        .dbus_req_vld (dbus_req_vld),
        .dbus_req_rdy (dbus_req_rdy),
        .dbus_req_pkt (dbus_req_pkt),
        .dbus_rsp_vld (dbus_rsp_vld),
        .dbus_rsp_rdy (dbus_rsp_rdy),
        .dbus_rsp_pkt (dbus_rsp_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && dbus_req_vld && dbus_req_rdy) bus_xfers++;
        if (!rst && ldst_rsp_vld && ldst_rsp_rdy) rsp_xfers++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit exp_trap(input ldst_req_pkt_t r);
        if (r.size == 2'd3) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (r.size == 2'd1 && (r.addr % 2) != 0) return 1'b1;
        if (r.size == 2'd2 && (r.addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Byte offset inside the word after rounding down to the access size
    function automatic int lane_off(input ldst_req_pkt_t r);
        int nb = 1 << r.size;
        return (int'(r.addr % 4) / nb) * nb;
    endfunction

    function automatic logic [3:0] exp_wstrb(input ldst_req_pkt_t r);
        int nb = 1 << r.size;
        int s  = ((1 << nb) - 1) << lane_off(r);
        return 4'(s);
    endfunction

    function automatic logic [31:0] exp_wdata(input ldst_req_pkt_t r);
        case (r.size)
            2'd0:    return (r.wdata & 32'hFF) * 32'h0101_0101;
            2'd1:    return (r.wdata & 32'hFFFF) * 32'h0001_0001;
            default: return r.wdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input ldst_req_pkt_t r, input logic [31:0] rd);
        int nb = 1 << r.size;
        int off = lane_off(r);
        longint unsigned mask = (64'd1 << (8 * nb)) - 1;
        longint unsigned v = ({32'd0, rd} >> (8 * off)) & mask;
        if (!r.is_unsigned && v[8*nb-1]) v = v | (64'hFFFF_FFFF & ~mask);
        return v[31:0];
    endfunction

    task automatic check_dbus(input ldst_req_pkt_t r);
        check("dbus_vld",  32'(dbus_req_vld), 32'd1);
        check("dbus_addr", dbus_req_pkt.addr, r.addr & 32'hFFFF_FFFC);
        check("dbus_we",   32'(dbus_req_pkt.we), 32'(r.is_store));
        check("dbus_wstrb", 32'(dbus_req_pkt.wstrb), r.is_store ? 32'(exp_wstrb(r)) : 32'd0);
        if (r.is_store) check("dbus_wdata", dbus_req_pkt.wdata, exp_wdata(r));
    endtask

    // One complete transaction; called right after a falling edge.
    // bus_dly >= TO means the bus never answers.
    task automatic run_txn(input ldst_req_pkt_t r, input int req_bp, input int bus_dly,
                           input logic [31:0] bus_rd, input logic bus_er, input int rsp_bp);
        bit          tr = exp_trap(r);
        bit          to = (bus_dly >= TO);
        logic [31:0] e_rd;
        logic        e_er;
        int          e_lat, lat, w, bx0, rx0;

        if (tr) begin
            e_rd = 32'd0; e_er = 1'b1; e_lat = 1;
        end else if (to) begin
            e_rd = 32'd0; e_er = 1'b1; e_lat = 2 + req_bp + TO;
        end else begin
            e_er  = bus_er;
            e_rd  = (bus_er || r.is_store) ? 32'd0 : exp_load(r, bus_rd);
            e_lat = 3 + req_bp + bus_dly;
        end

        bx0 = bus_xfers;
        rx0 = rsp_xfers;
        ldst_req_pkt = r;
        ldst_req_vld = 1'b1;
        w = 0;
        while (!ldst_req_rdy && w < LIM) begin
            @(negedge clk); w++;
        end
        check("req_accept", 32'(w < LIM), 32'd1);
        @(negedge clk);
        ldst_req_vld = 1'b0;
        ldst_req_pkt = {$urandom, $urandom, 3'($urandom)};
        lat = 1;

        if (!tr) begin
            for (int i = 0; i <= req_bp; i++) begin
                check_dbus(r);
                if (i == req_bp) begin
                    last_daddr  = dbus_req_pkt.addr;
                    last_dwe    = dbus_req_pkt.we;
                    last_dwdata = dbus_req_pkt.wdata;
                    last_dwstrb = dbus_req_pkt.wstrb;
                end
                dbus_req_rdy = (i == req_bp);
                @(negedge clk); lat++;
            end
            dbus_req_rdy = 1'b0;
            if (!to) begin
                for (int i = 0; i <= bus_dly; i++) begin
                    if (i == 0) check("dbus_rsp_rdy", 32'(dbus_rsp_rdy), 32'd1);
                    dbus_rsp_pkt = '{rdata: bus_rd, err: bus_er};
                    dbus_rsp_vld = (i == bus_dly);
                    @(negedge clk); lat++;
                end
                dbus_rsp_vld = 1'b0;
                dbus_rsp_pkt = {$urandom, 1'($urandom)};
            end
        end

        w = 0;
        while (!ldst_rsp_vld && w < LIM) begin
            @(negedge clk); lat++; w++;
        end
        check("rsp_latency", lat, e_lat);

        for (int i = 0; i <= rsp_bp; i++) begin
            check("rsp_vld",   32'(ldst_rsp_vld), 32'd1);
            check("rsp_rdata", ldst_rsp_pkt.rdata, e_rd);
            check("rsp_err",   32'(ldst_rsp_pkt.err), 32'(e_er));
            check("req_rdy_busy", 32'(ldst_req_rdy), 32'd0);
            last_rd = ldst_rsp_pkt.rdata;
            last_er = ldst_rsp_pkt.err;
            ldst_rsp_rdy = (i == rsp_bp);
            @(negedge clk);
        end
        ldst_rsp_rdy = 1'b0;
        check("rsp_vld_after", 32'(ldst_rsp_vld), 32'd0);
        check("req_rdy_idle",  32'(ldst_req_rdy), 32'd1);
        check("bus_xfer_cnt",  bus_xfers - bx0, tr ? 32'd0 : 32'd1);
        check("rsp_xfer_cnt",  rsp_xfers - rx0, 32'd1);
    endtask

    function automatic ldst_req_pkt_t mk(input logic [31:0] a, input logic [31:0] d,
                                         input logic st, input logic [1:0] sz, input logic u);
        ldst_req_pkt_t p;
        p.addr = a; p.wdata = d; p.is_store = st; p.size = sz; p.is_unsigned = u;
        return p;
    endfunction

    initial begin
        rst = 1'b1;
        ldst_req_vld = 1'b0; ldst_req_pkt = '0;
        ldst_rsp_rdy = 1'b0;
        dbus_req_rdy = 1'b0;
        dbus_rsp_vld = 1'b0; dbus_rsp_pkt = '0;
        last_rd = '0; last_er = 1'b0; last_daddr = '0; last_dwdata = '0;
        last_dwe = 1'b0; last_dwstrb = '0;

        repeat (3) @(negedge clk);
        check("rst_req_rdy",  32'(ldst_req_rdy), 32'd0);
        check("rst_rsp_vld",  32'(ldst_rsp_vld), 32'd0);
        check("rst_dbus_vld", 32'(dbus_req_vld), 32'd0);
        check("rst_dbus_rdy", 32'(dbus_rsp_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_rdy",  32'(ldst_req_rdy), 32'd1);
        check("idle_dbus_rdy", 32'(dbus_rsp_rdy), 32'd1);
        check("idle_rsp_pkt",  {ldst_rsp_pkt.rdata[30:0], ldst_rsp_pkt.err}, 32'd0);

        // load word, no backpressure
        run_txn(mk(32'h100, 32'h0, 1'b0, LDST_SIZE_W, 1'b0), 0, 0, 32'hDEADBEEF, 1'b0, 0);
        check("t_lw_rdata", last_rd, 32'hDEADBEEF);
        check("t_lw_addr",  last_daddr, 32'h100);
        check("t_lw_we",    32'(last_dwe), 32'd0);

        // signed / unsigned byte load
        run_txn(mk(32'h103, 32'h0, 1'b0, LDST_SIZE_B, 1'b0), 0, 0, 32'h80112233, 1'b0, 0);
        check("t_lb_s", last_rd, 32'hFFFFFF80);
        run_txn(mk(32'h103, 32'h0, 1'b0, LDST_SIZE_B, 1'b1), 0, 0, 32'h80112233, 1'b0, 0);
        check("t_lb_u", last_rd, 32'h00000080);

        // store half
        run_txn(mk(32'h202, 32'h1234ABCD, 1'b1, LDST_SIZE_H, 1'b0), 0, 1, 32'h55555555, 1'b0, 0);
        check("t_sh_addr",  last_daddr, 32'h200);
        check("t_sh_wdata", last_dwdata, 32'hABCDABCD);
        check("t_sh_wstrb", 32'(last_dwstrb), 32'hC);
        check("t_sh_rsp",   {last_rd[30:0], last_er}, 32'd0);

        // bus never answers, then a normal request
        run_txn(mk(32'h300, 32'h0, 1'b0, LDST_SIZE_W, 1'b0), 0, 99, 32'h0, 1'b0, 0);
        check("t_to_err", 32'(last_er), 32'd1);
        run_txn(mk(32'h304, 32'h0, 1'b0, LDST_SIZE_H, 1'b1), 0, 2, 32'hCAFEF00D, 1'b0, 0);

        // backpressure on both sides
        run_txn(mk(32'h400, 32'h89ABCDEF, 1'b1, LDST_SIZE_B, 1'b0), 5, 0, 32'h0, 1'b1, 3);

        // misaligned word
        run_txn(mk(32'h101, 32'h0, 1'b0, LDST_SIZE_W, 1'b0), 0, 0, 32'h11223344, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t_mis_err", 32'(last_er), 32'd1);
`else
        check("t_mis_addr",  last_daddr, 32'h100);
        check("t_mis_rdata", last_rd, 32'h11223344);
`endif

        // illegal size
        run_txn(mk(32'h500, 32'h0, 1'b0, 2'd3, 1'b0), 0, 0, 32'h0, 1'b0, 0);

        // reset while waiting for the bus
        ldst_req_pkt = mk(32'h40, 32'h0, 1'b0, LDST_SIZE_W, 1'b0);
        ldst_req_vld = 1'b1;
        @(negedge clk);
        ldst_req_vld = 1'b0;
        dbus_req_rdy = 1'b1;
        @(negedge clk);
        dbus_req_rdy = 1'b0;
        check("wait_dbus_rdy", 32'(dbus_rsp_rdy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rsp_vld",  32'(ldst_rsp_vld), 32'd0);
        check("mid_rst_dbus_vld", 32'(dbus_req_vld), 32'd0);
        check("mid_rst_req_rdy",  32'(ldst_req_rdy), 32'd0);
        check("mid_rst_dbus_rdy", 32'(dbus_rsp_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_rdy", 32'(ldst_req_rdy), 32'd1);
        @(negedge clk);
        run_txn(mk(32'h44, 32'h0, 1'b0, LDST_SIZE_H, 1'b0), 0, 0, 32'h8000_7FFF, 1'b0, 0);

        // random traffic
        for (int t = 0; t < 200; t++) begin
            int          sel = $urandom_range(0, 7);
            logic [1:0]  sz  = (sel == 7) ? 2'd3 : 2'(sel % 3);
            ldst_req_pkt_t p = mk($urandom, $urandom, 1'($urandom), sz, 1'($urandom));
            run_txn(p, $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
